// File: rtl/reservoir_pkg.sv
// rtl/reservoir_pkg.sv - shared types, constants and saturation helper for the reservoir readout
package reservoir_pkg;

  localparam int N_NEURONS = 10;
  localparam int Q_FRAC    = 10;

  typedef logic signed [15:0] q6_10_t;

  typedef enum logic [1:0] {COLLECT, MAC, OUT} state_t;

  function automatic q6_10_t sat16(input logic signed [31:0] a);
    if (a > 32'sd32767)
      return 16'sh7FFF;
    else if (a < -32'sd32768)
      return 16'sh8000;
    else
      return a[15:0];
  endfunction

endpackage

// File: rtl/spike_window_counter.sv
// rtl/spike_window_counter.sv - per-neuron spike counts over a fixed enabled-cycle window
// Snapshot includes the closing cycle's spikes; the next window starts on the following cycle.
module spike_window_counter
  import reservoir_pkg::*;
#(
  parameter int N   = N_NEURONS,
  parameter int WIN = 16,
  parameter int CW  = $clog2(WIN + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_en,
  input  logic [N-1:0]    i_spikes,
  output logic            o_close,
  output logic [N*CW-1:0] o_cnt_snap
);

  localparam logic [CW-1:0] WC_LAST = CW'(WIN - 1);

  logic [CW-1:0]   r_wc;
  logic [CW-1:0]   r_cnt [N];
  logic [N*CW-1:0] r_snap;
  logic            w_close;

  assign w_close    = i_en && (r_wc == WC_LAST);
  assign o_close    = w_close;
  assign o_cnt_snap = r_snap;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wc   <= '0;
      r_snap <= '0;
      for (int k = 0; k < N; k++) r_cnt[k] <= '0;
    end else if (i_en) begin
      if (w_close) begin
        r_wc <= '0;
        for (int k = 0; k < N; k++) begin
          r_snap[k*CW +: CW] <= r_cnt[k] + CW'(i_spikes[k]);
          r_cnt[k]           <= '0;
        end
      end else begin
        r_wc <= r_wc + CW'(1);
        for (int k = 0; k < N; k++) r_cnt[k] <= r_cnt[k] + CW'(i_spikes[k]);
      end
    end
  end

endmodule

// File: rtl/reservoir_readout.sv
// rtl/reservoir_readout.sv - windowed spike counts fed through a sequential Q6.10 linear readout
// One MAC term per cycle; bias is folded into the first term so a same-cycle bias write is seen.
module reservoir_readout
  import reservoir_pkg::*;
#(
  parameter int N   = N_NEURONS,
  parameter int WIN = 16,
  parameter int CW  = $clog2(WIN + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] spikes,
  input  logic [15:0]  target,
  input  logic         w_we,
  input  logic [3:0]   w_addr,
  input  logic [15:0]  w_data,
  output logic [15:0]  y_hat,
  output logic         y_valid,
  output logic [17:0]  err,
  output logic         busy,
  output logic         sat
);

  if (WIN < N + 2) begin : g_win_check
    $error("reservoir_readout: WIN must be at least N+2");
  end

  localparam logic [3:0] BIAS_ADDR = 4'(N);
  localparam logic [3:0] LAST_IDX  = 4'(N - 1);
  localparam int         PW        = 16 + CW + 1;

  state_t             r_state;
  logic [3:0]         r_idx;
  logic signed [31:0] r_acc;
  q6_10_t             r_w [N];
  q6_10_t             r_bias;
  logic [15:0]        r_target_snap;
  logic [15:0]        r_y_hat;
  logic [17:0]        r_err;
  logic               r_y_valid;
  logic               r_busy;
  logic               r_sat;

  logic               w_close;
  logic [N*CW-1:0]    w_cnt_snap;
  logic [CW-1:0]      w_snap [N];
  logic signed [PW-1:0] w_cnt_ext;
  logic signed [PW-1:0] w_wgt_ext;
  logic signed [PW-1:0] w_prod;
  logic signed [31:0] w_term;
  logic signed [31:0] w_base;
  q6_10_t             w_sat16;
  logic               w_clamped;

  spike_window_counter #(
    .N   (N),
    .WIN (WIN),
    .CW  (CW)
  ) u_counter (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_en       (en),
    .i_spikes   (spikes),
    .o_close    (w_close),
    .o_cnt_snap (w_cnt_snap)
  );

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign w_snap[g] = w_cnt_snap[g*CW +: CW];
  end

  // Count is non-negative, so it is zero-extended before the signed multiply.
  assign w_cnt_ext = {{(PW - CW){1'b0}}, w_snap[r_idx]};
  assign w_wgt_ext = {{(PW - 16){r_w[r_idx][15]}}, r_w[r_idx]};
  assign w_prod    = w_cnt_ext * w_wgt_ext;
  assign w_term    = {{(32 - PW){w_prod[PW-1]}}, w_prod};
  assign w_base    = (r_idx == 4'd0) ? {{16{r_bias[15]}}, r_bias} : r_acc;

  assign w_sat16   = sat16(r_acc);
  assign w_clamped = (r_acc != {{16{w_sat16[15]}}, w_sat16});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= COLLECT;
      r_idx         <= '0;
      r_acc         <= '0;
      r_bias        <= '0;
      r_target_snap <= '0;
      r_y_hat       <= '0;
      r_err         <= '0;
      r_y_valid     <= 1'b0;
      r_busy        <= 1'b0;
      r_sat         <= 1'b0;
      for (int k = 0; k < N; k++) r_w[k] <= '0;
    end else begin
      r_y_valid <= 1'b0;
      if (w_we && !r_busy) begin
        if (w_addr < BIAS_ADDR)
          r_w[w_addr] <= w_data;
        else if (w_addr == BIAS_ADDR)
          r_bias <= w_data;
      end
      case (r_state)
        COLLECT: begin
          if (w_close) begin
            r_target_snap <= target;
            r_idx         <= '0;
            r_busy        <= 1'b1;
            r_state       <= MAC;
          end
        end
        MAC: begin
          r_acc <= w_base + w_term;
          if (r_idx == LAST_IDX)
            r_state <= OUT;
          else
            r_idx <= r_idx + 4'd1;
        end
        OUT: begin
          r_y_hat   <= w_sat16;
          r_err     <= {2'b00, r_target_snap} - {{2{w_sat16[15]}}, w_sat16};
          if (w_clamped) r_sat <= 1'b1;
          r_y_valid <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= COLLECT;
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign y_hat   = r_y_hat;
  assign y_valid = r_y_valid;
  assign err     = r_err;
  assign busy    = r_busy;
  assign sat     = r_sat;

endmodule

// File: tb/tb_reservoir_readout.sv
// tb/tb_reservoir_readout.sv - scoreboard bench for reservoir_readout against a window-level model
module tb_reservoir_readout;

  localparam int N   = 10;
  localparam int WIN = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [N-1:0]  spikes;
  logic [15:0]   target;
  logic          w_we;
  logic [3:0]    w_addr;
  logic [15:0]   w_data;
  logic [15:0]   y_hat;
  logic          y_valid;
  logic [17:0]   err;
  logic          busy;
  logic          sat;

  reservoir_readout #(.N(N), .WIN(WIN)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .spikes  (spikes),
    .target  (target),
    .w_we    (w_we),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .y_hat   (y_hat),
    .y_valid (y_valid),
    .err     (err),
    .busy    (busy),
    .sat     (sat)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int yhat;
    int err;
    int sat;
    int edge_no;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  int  m_cnt [N];
  int  m_wc;
  int  m_w [N];
  int  m_bias;
  int  m_busy_left;
  int  m_sat;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < N; k++) begin
      m_cnt[k] = 0;
      m_w[k]   = 0;
    end
    m_wc        = 0;
    m_bias      = 0;
    m_busy_left = 0;
    m_sat       = 0;
    sbq.delete();
  endtask

  // Prediction for a window closing at the upcoming edge.
  task automatic predict(input logic [15:0] tg);
    longint acc;
    int     y;
    exp_t   e;
    acc = m_bias;
    for (int k = 0; k < N; k++) acc += longint'(m_cnt[k]) * longint'(m_w[k]);
    if (acc > 32767)       y = 32767;
    else if (acc < -32768) y = -32768;
    else                   y = int'(acc);
    if (longint'(y) != acc) m_sat = 1;
    e.yhat    = y;
    e.err     = int'(tg) - y;
    e.sat     = m_sat;
    e.edge_no = cyc + 1 + N + 1;
    sbq.push_back(e);
  endtask

  task automatic step(input bit e, input logic [N-1:0] sp, input logic [15:0] tg,
                      input bit we, input logic [3:0] a, input logic [15:0] d);
    en = e; spikes = sp; target = tg; w_we = we; w_addr = a; w_data = d;
    if (we && m_busy_left == 0) begin
      if (int'(a) < N)       m_w[a] = int'($signed(d));
      else if (int'(a) == N) m_bias = int'($signed(d));
    end
    if (m_busy_left > 0) m_busy_left--;
    if (e) begin
      for (int k = 0; k < N; k++) m_cnt[k] += int'(sp[k]);
      m_wc++;
      if (m_wc == WIN) begin
        predict(tg);
        for (int k = 0; k < N; k++) m_cnt[k] = 0;
        m_wc        = 0;
        m_busy_left = N + 1;
      end
    end
    @(posedge clk); #1;
    chk("busy", int'(busy), int'(m_busy_left > 0));
  endtask

  task automatic idle(input int n, input bit e);
    for (int i = 0; i < n; i++) step(e, '0, 16'h0, 1'b0, 4'h0, 16'h0);
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; spikes = '0; target = '0; w_we = 1'b0; w_addr = '0; w_data = '0;
    #2;
    chk("rst_y_hat", int'(y_hat), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_y_valid", int'(y_valid), 0);
    chk("rst_sat", int'(sat), 0);
    model_clear();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (sbq.size() > 0 && cyc > sbq[0].edge_no) begin
        mon_e = sbq.pop_front();
        checks++; errors++;
        $display("FAIL missing_y_valid actual=none expected_at_cycle=%0d (cycle %0d)", mon_e.edge_no, cyc);
      end
      if (y_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_y_valid actual=1 expected=0 (cycle %0d)", cyc);
        end else begin
          mon_e = sbq.pop_front();
          chk("y_valid_cycle", cyc, mon_e.edge_no);
          chk("y_hat", int'($signed(y_hat)), mon_e.yhat);
          chk("err", int'($signed(err)), mon_e.err);
          chk("sat", int'(sat), mon_e.sat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] all_one;
    logic [N-1:0] n0;
    all_one = '1;
    n0      = N'(1);
    rst = 1'b0; en = 1'b0; spikes = '0; target = '0; w_we = 1'b0; w_addr = '0; w_data = '0;
    #1;

    // Neuron 0 at weight 1.0 over a full window.
    do_reset();
    step(1'b0, '0, 16'h0, 1'b1, 4'd0, 16'h0400);
    for (int i = 0; i < WIN; i++) step(1'b1, n0, 16'h0, 1'b0, 4'h0, 16'h0);
    idle(13, 1'b0);

    // Every neuron saturating with bias -1.0.
    do_reset();
    for (int k = 0; k < N; k++) step(1'b0, '0, 16'h0, 1'b1, 4'(k), 16'h0400);
    step(1'b0, '0, 16'h0, 1'b1, 4'(N), 16'hFC00);
    for (int i = 0; i < WIN; i++) step(1'b1, all_one, 16'h0, 1'b0, 4'h0, 16'h0);
    idle(13, 1'b0);

    // Error path: zero prediction vs target 2.0, then max bias vs target 0.
    do_reset();
    for (int i = 0; i < WIN; i++) step(1'b1, N'($urandom), 16'h0800, 1'b0, 4'h0, 16'h0);
    idle(13, 1'b0);
    step(1'b0, '0, 16'h0, 1'b1, 4'(N), 16'h7FFF);
    for (int i = 0; i < WIN; i++) step(1'b1, N'($urandom), 16'h0000, 1'b0, 4'h0, 16'h0);
    idle(13, 1'b0);

    // Enable gap of 5 cycles mid-window with spikes that must not count.
    do_reset();
    for (int k = 0; k < N; k++) step(1'b0, '0, 16'h0, 1'b1, 4'(k), 16'($urandom_range(0, 1023)));
    for (int i = 0; i < 8; i++) step(1'b1, N'($urandom), 16'h0123, 1'b0, 4'h0, 16'h0);
    for (int i = 0; i < 5; i++) step(1'b0, all_one, 16'h0123, 1'b0, 4'h0, 16'h0);
    for (int i = 0; i < 8; i++) step(1'b1, N'($urandom), 16'h0456, 1'b0, 4'h0, 16'h0);
    idle(13, 1'b0);

    // Weight write while busy must be dropped.
    do_reset();
    step(1'b0, '0, 16'h0, 1'b1, 4'd0, 16'h0400);
    for (int i = 0; i < WIN; i++) step(1'b1, n0, 16'h0, 1'b0, 4'h0, 16'h0);
    for (int i = 0; i < 3; i++) step(1'b1, n0, 16'h0, 1'b1, 4'd0, 16'h0800);
    for (int i = 0; i < WIN - 3; i++) step(1'b1, n0, 16'h0, 1'b0, 4'h0, 16'h0);
    idle(13, 1'b0);

    // Reset in the middle of a MAC, then a clean window.
    do_reset();
    for (int k = 0; k <= N; k++) step(1'b0, '0, 16'h0, 1'b1, 4'(k), 16'($urandom_range(0, 2047)));
    for (int i = 0; i < WIN; i++) step(1'b1, N'($urandom), 16'h0200, 1'b0, 4'h0, 16'h0);
    idle(3, 1'b1);
    do_reset();
    idle(14, 1'b0);
    for (int k = 0; k <= N; k++) step(1'b0, '0, 16'h0, 1'b1, 4'(k), 16'($urandom_range(0, 2047)));
    for (int i = 0; i < WIN; i++) step(1'b1, N'($urandom), 16'h0300, 1'b0, 4'h0, 16'h0);
    idle(13, 1'b0);

    // Random traffic: gaps, spikes, targets and writes at any time.
    do_reset();
    for (int i = 0; i < 140; i++)
      step($urandom_range(0, 9) != 0, N'($urandom), 16'($urandom),
           $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)), 16'($urandom));

    for (int i = 0; i < 40 && sbq.size() > 0; i++) idle(1, 1'b0);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
